// File: rtl/stream_register_file.sv
// Stream register file: per-stream data plus produced/unconsumed valid bits, dual-operand reads.
// Optional same-cycle write forwarding into reads is enabled by defining SRF_BYPASS_EN.
module stream_register_file #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_STREAM_ID = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        srf_write_enable,
  input  logic [NUM_STREAM_ID-1:0]    stream_dest,
  input  logic [DATA_WIDTH-1:0]       write_data,
  input  logic                        srf_read_enable,
  input  logic                        srf_consume,
  input  logic [NUM_STREAM_ID-1:0]    stream_src1,
  input  logic [NUM_STREAM_ID-1:0]    stream_src2,
  output logic [DATA_WIDTH-1:0]       srf_data1,
  output logic [DATA_WIDTH-1:0]       srf_data2,
  output logic                        srf_read_valid,
  output logic                        srf_stall,
  output logic                        srf_overwrite_err,
  output logic [2**NUM_STREAM_ID-1:0] stream_valid_mask
);

  localparam int NUM_STREAMS = 2**NUM_STREAM_ID;

  logic [DATA_WIDTH-1:0]  mem [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] valid;
  logic [NUM_STREAMS-1:0] valid_next;
  logic                   hit1;
  logic                   hit2;
  logic                   accept;
  logic                   consume_now;
  logic                   dest_consumed;
  logic                   fwd_consumed;
  logic                   err_next;

`ifdef SRF_BYPASS_EN
  assign hit1 = srf_write_enable && (stream_dest == stream_src1);
  assign hit2 = srf_write_enable && (stream_dest == stream_src2);
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  // When src1 == src2 both terms index the same bit, so only one stream is checked.
  assign accept = srf_read_enable && (valid[stream_src1] || hit1)
                                  && (valid[stream_src2] || hit2);
  assign srf_stall     = srf_read_enable && !accept;
  assign consume_now   = accept && srf_consume;
  assign dest_consumed = consume_now && ((stream_dest == stream_src1) || (stream_dest == stream_src2));
  assign fwd_consumed  = consume_now && (hit1 || hit2);
  assign err_next      = srf_write_enable && valid[stream_dest] && !dest_consumed;
  assign stream_valid_mask = valid;

  // A write normally beats a same-cycle consume; a forwarded write that is consumed ends invalid.
  always_comb begin
    valid_next = valid;
    if (consume_now) begin
      valid_next[stream_src1] = 1'b0;
      valid_next[stream_src2] = 1'b0;
    end
    if (srf_write_enable && !fwd_consumed) begin
      valid_next[stream_dest] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srf_write_enable) begin
      mem[stream_dest] <= write_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid             <= '0;
      srf_data1         <= '0;
      srf_data2         <= '0;
      srf_read_valid    <= 1'b0;
      srf_overwrite_err <= 1'b0;
    end else begin
      valid             <= valid_next;
      srf_read_valid    <= accept;
      srf_overwrite_err <= err_next;
      if (accept) begin
        srf_data1 <= hit1 ? write_data : mem[stream_src1];
        srf_data2 <= hit2 ? write_data : mem[stream_src2];
      end
    end
  end

endmodule
